// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: PC width, default
// vectors, fetch FSM states and the redirect-target conditioning helper.
// No ports (package).
package pc_seq_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0180;
  localparam int unsigned     DEFAULT_TIMEOUT      = 16;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Condition a redirect destination. With trapping enabled a misaligned
  // target is replaced by the trap vector; otherwise the low bits are
  // simply cleared so the PC stays word aligned.
  function automatic logic [PC_W-1:0] redirect_pc(
    input logic [PC_W-1:0] target,
    input logic            trap_en,
    input logic [PC_W-1:0] trap_vec
  );
    if (trap_en && (target[1:0] != 2'b00)) begin
      return trap_vec;
    end
    return {target[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Combinational sequential-address generator: pc_plus4 = pc_in + 4 (modulo 2^32).
// Ports: pc_in (current PC), pc_plus4 (PC + 4, wraps with no carry out).
// Latency: zero (pure combinational).
module pc_incrementer
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0] pc_in,
  output logic [PC_W-1:0] pc_plus4
);

  assign pc_plus4 = pc_in + PC_W'(4);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the MIPS datapath:
// picks next PC (Jump > BranchTaken > PC+4), runs the IMem req/ready handshake,
// honours Stall/Halt and halts with a sticky FetchErr if memory stalls too long.
// Ports: Clk/Reset (async, active-high); Stall, BranchTaken/BranchTarget,
//   Jump/JumpTarget, Halt, IMemReady in; IMemReq, PCResult, PCAddResult,
//   InstrValid, FetchErr, Trap out.
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned redirects load
//   TRAP_VECTOR and pulse Trap; when undefined targets are word-aligned and
//   Trap is tied low.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Halt,
  input  logic        IMemReady,
  output logic        IMemReq,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult,
  output logic        InstrValid,
  output logic        FetchErr,
  output logic        Trap
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              fetch_err_q, fetch_err_d;

  logic [PC_W-1:0]   pc_plus4;
  logic              active;
  logic              take_halt;
  logic              take_redirect;
  logic [PC_W-1:0]   redirect_tgt;
  logic [PC_W-1:0]   redirect_dst;
  logic [CNT_W-1:0]  wait_cnt_inc;
  logic              imem_req;
  logic              instr_valid;

  pc_incrementer u_pc_incrementer (
    .pc_in    (pc_q),
    .pc_plus4 (pc_plus4)
  );

  // Jump beats BranchTaken; a branch arriving with a jump is dropped.
  assign redirect_tgt = Jump ? JumpTarget : BranchTarget;
  assign redirect_dst = redirect_pc(redirect_tgt, TRAP_EN, TRAP_VECTOR);

  // Halt and redirects only act once the sequencer has left BOOT and while
  // it is still running; HALTED is exited only by Reset.
  assign active        = (state_q == FETCH) || (state_q == HOLD);
  assign take_halt     = active & Halt;
  assign take_redirect = active & ~Halt & (Jump | BranchTaken);

  assign wait_cnt_inc  = wait_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wait_cnt_d  = '0;
    fetch_err_d = fetch_err_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (take_halt) begin
          state_d = HALTED;
        end else if (take_redirect) begin
          // In-flight fetch is squashed: no InstrValid this cycle.
          pc_d = redirect_dst;
        end else if (IMemReady) begin
          instr_valid = 1'b1;
          if (Stall) begin
            state_d = HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end else if (wait_cnt_inc == CNT_MAX) begin
          fetch_err_d = 1'b1;
          state_d     = HALTED;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      HOLD: begin
        if (take_halt) begin
          state_d = HALTED;
        end else if (take_redirect) begin
          pc_d    = redirect_dst;
          state_d = FETCH;
        end else if (!Stall) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Trap is registered so it lines up with the cycle PCResult shows TRAP_VECTOR.
  logic trap_q, trap_d;

  always_comb begin
    trap_d = take_redirect & (redirect_tgt[1:0] != 2'b00);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign Trap = trap_q;
`else
  assign Trap = 1'b0;
`endif

  assign IMemReq     = imem_req;
  assign InstrValid  = instr_valid;
  assign PCResult    = pc_q;
  assign PCAddResult = pc_plus4;
  assign FetchErr    = fetch_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, stall,
// redirect priority, misaligned redirect, PC wrap, watchdog, reset and halt.
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Halt;
  logic        IMemReady;
  logic        IMemReq;
  logic [31:0] PCResult;
  logic [31:0] PCAddResult;
  logic        InstrValid;
  logic        FetchErr;
  logic        Trap;

  int n_total = 0;
  int n_pass  = 0;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Halt         (Halt),
    .IMemReady    (IMemReady),
    .IMemReq      (IMemReq),
    .PCResult     (PCResult),
    .PCAddResult  (PCAddResult),
    .InstrValid   (InstrValid),
    .FetchErr     (FetchErr),
    .Trap         (Trap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    Jump = 1'b0; JumpTarget = '0; Halt = 1'b0; IMemReady = 1'b1;
    #1;
    chk("rst_pc",   PCResult,   32'h0);
    chk("rst_req",  IMemReq,    1'b0);
    chk("rst_iv",   InstrValid, 1'b0);
    chk("rst_ferr", FetchErr,   1'b0);
    chk("rst_trap", Trap,       1'b0);

    // Sequential fetch
    @(negedge Clk); Reset = 1'b0; #1;
    chk("boot_req", IMemReq, 1'b0);
    chk("boot_iv",  InstrValid, 1'b0);
    @(negedge Clk); #1;
    chk("f0_pc",  PCResult,    32'h0);
    chk("f0_req", IMemReq,     1'b1);
    chk("f0_iv",  InstrValid,  1'b1);
    chk("f0_add", PCAddResult, 32'h4);
    @(negedge Clk); #1;
    chk("f4_pc", PCResult,   32'h4);
    chk("f4_iv", InstrValid, 1'b1);

    // Stall for three cycles at PC=8
    @(negedge Clk); Stall = 1'b1; #1;
    chk("st1_pc", PCResult,   32'h8);
    chk("st1_iv", InstrValid, 1'b1);
    @(negedge Clk); #1;
    chk("st2_pc",  PCResult,   32'h8);
    chk("st2_req", IMemReq,    1'b0);
    chk("st2_iv",  InstrValid, 1'b0);
    @(negedge Clk); #1;
    chk("st3_pc", PCResult,   32'h8);
    chk("st3_iv", InstrValid, 1'b0);
    @(negedge Clk); Stall = 1'b0; #1;
    chk("st_rel_pc", PCResult,   32'h8);
    chk("st_rel_iv", InstrValid, 1'b0);
    @(negedge Clk); #1;
    chk("fc_pc", PCResult,   32'hC);
    chk("fc_iv", InstrValid, 1'b1);

    // Jump and branch together: jump wins, fetch squashed
    Jump = 1'b1; JumpTarget = 32'h40; BranchTaken = 1'b1; BranchTarget = 32'h80; #1;
    chk("jb_iv", InstrValid, 1'b0);
    @(negedge Clk); Jump = 1'b0; BranchTaken = 1'b0; #1;
    chk("jb_pc", PCResult,   32'h40);
    chk("jb_iv2", InstrValid, 1'b1);
    @(negedge Clk); #1;
    chk("f44_pc", PCResult, 32'h44);

    // Misaligned branch target
    BranchTaken = 1'b1; BranchTarget = 32'h42; #1;
    chk("mis_iv", InstrValid, 1'b0);
    @(negedge Clk); BranchTaken = 1'b0; #1;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc",   PCResult, 32'h180);
    chk("mis_trap", Trap,     1'b1);
    @(negedge Clk); #1;
    chk("mis_pc2",   PCResult, 32'h184);
    chk("mis_trap2", Trap,     1'b0);
`else
    chk("mis_pc",   PCResult, 32'h40);
    chk("mis_trap", Trap,     1'b0);
    @(negedge Clk); #1;
    chk("mis_pc2",   PCResult, 32'h44);
    chk("mis_trap2", Trap,     1'b0);
`endif

    // 32-bit wrap
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC; #1;
    @(negedge Clk); Jump = 1'b0; #1;
    chk("wrap_pc",  PCResult,    32'hFFFF_FFFC);
    chk("wrap_add", PCAddResult, 32'h0);
    chk("wrap_iv",  InstrValid,  1'b1);
    @(negedge Clk); #1;
    chk("wrap_pc2", PCResult, 32'h0);

    // Watchdog: redirect to 0x20 while memory is not ready, then 16 wait cycles
    Jump = 1'b1; JumpTarget = 32'h20; IMemReady = 1'b0; #1;
    @(negedge Clk); Jump = 1'b0; #1;
    chk("wd_pc",  PCResult,   32'h20);
    chk("wd_req", IMemReq,    1'b1);
    chk("wd_iv",  InstrValid, 1'b0);
    repeat (15) @(negedge Clk);
    #1;
    chk("wd15_ferr", FetchErr, 1'b0);
    chk("wd15_req",  IMemReq,  1'b1);
    @(negedge Clk); #1;
    chk("wd_ferr",  FetchErr, 1'b1);
    chk("wd_req0",  IMemReq,  1'b0);
    chk("wd_pcfrz", PCResult, 32'h20);
    IMemReady = 1'b1; Jump = 1'b1; JumpTarget = 32'h60; #1;
    @(negedge Clk); Jump = 1'b0; #1;
    chk("halt_pc",   PCResult,   32'h20);
    chk("halt_ferr", FetchErr,   1'b1);
    chk("halt_iv",   InstrValid, 1'b0);

    // Reset clears the sticky error
    Reset = 1'b1; #1;
    chk("rst2_ferr", FetchErr, 1'b0);
    chk("rst2_pc",   PCResult, 32'h0);
    @(negedge Clk); Reset = 1'b0; #1;
    @(negedge Clk); #1;
    chk("rst2_req", IMemReq, 1'b1);

    // Reset mid-wait at PC=0x20
    Jump = 1'b1; JumpTarget = 32'h20; IMemReady = 1'b0; #1;
    @(negedge Clk); Jump = 1'b0; #1;
    chk("mw_pc", PCResult, 32'h20);
    repeat (3) @(negedge Clk);
    #2; Reset = 1'b1; #1;
    chk("mw_rst_pc",  PCResult, 32'h0);
    chk("mw_rst_req", IMemReq,  1'b0);
    @(negedge Clk); Reset = 1'b0; #1;
    chk("mw_boot_req", IMemReq, 1'b0);
    @(negedge Clk); #1;
    chk("mw_f_req", IMemReq,  1'b1);
    chk("mw_f_pc",  PCResult, 32'h0);
    repeat (14) @(negedge Clk);
    #1;
    chk("mw15_ferr", FetchErr, 1'b0);
    chk("mw15_req",  IMemReq,  1'b1);
    IMemReady = 1'b1; #1;
    chk("mw_acc_iv", InstrValid, 1'b1);
    @(negedge Clk); #1;
    chk("mw_acc_pc", PCResult, 32'h4);

    // Halt from FETCH
    Halt = 1'b1; #1;
    chk("hl_iv", InstrValid, 1'b0);
    @(negedge Clk); Halt = 1'b0; #1;
    chk("hl_req", IMemReq,  1'b0);
    chk("hl_pc",  PCResult, 32'h4);
    @(negedge Clk); #1;
    chk("hl_req2", IMemReq,  1'b0);
    chk("hl_pc2",  PCResult, 32'h4);
    chk("hl_ferr", FetchErr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
